// File: rtl/ioctl_rom_loader.sv
// ioctl_rom_loader: routes one HPS ioctl download image into NUM_REGIONS
// independent ROM write ports. The CPU is held in reset for the duration of
// the load plus a short tail, and the loader reports the byte count,
// checksum and error status when the load finishes.
module ioctl_rom_loader #(
  parameter int unsigned ADDR_W      = 25,
  parameter int unsigned NUM_REGIONS = 4,
  parameter int unsigned REGION_AW   = 15,
  parameter logic [7:0]  LOAD_INDEX  = 8'd1,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ioctl_download,
  input  logic [7:0]             ioctl_index,
  input  logic                   ioctl_wr,
  input  logic [ADDR_W-1:0]      ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  output logic                   ioctl_wait,
  output logic [NUM_REGIONS-1:0] rom_we,
  output logic [REGION_AW-1:0]   rom_addr,
  output logic [7:0]             rom_data,
  input  logic                   rom_ack,
  output logic                   cpu_hold,
  output logic                   load_done,
  output logic                   load_ok,
  output logic [ADDR_W-1:0]      byte_count,
  output logic [15:0]            checksum,
  output logic                   err_overflow,
  output logic                   err_protocol
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_WRITE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Registered outputs
  logic                   r_ioctl_wait;
  logic [NUM_REGIONS-1:0] r_rom_we;
  logic [REGION_AW-1:0]   r_rom_addr;
  logic [7:0]             r_rom_data;
  logic                   r_cpu_hold;
  logic                   r_load_done;
  logic                   r_load_ok;
  logic [ADDR_W-1:0]      r_byte_count;
  logic [15:0]            r_checksum;
  logic                   r_err_overflow;
  logic                   r_err_protocol;
  logic [7:0]             r_hold_cnt;

  // Address decode and FSM strobes
  logic [ADDR_W-1:0]      w_region;
  logic [NUM_REGIONS-1:0] w_sel;
  logic                   w_in_range;
  logic                   w_start;
  logic                   w_clear;
  logic                   w_accept;
  logic                   w_overflow;
  logic                   w_commit;
  logic                   w_proto;
  logic                   w_finish;

  assign w_region   = ioctl_addr >> REGION_AW;
  assign w_in_range = |w_sel;
  assign w_start    = ioctl_download && (ioctl_index == LOAD_INDEX);

  // One-hot region select; all-zero when the address lies past the last region
  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      w_sel[i] = (w_region == ADDR_W'(i));
    end
  end

  // State register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and single-cycle datapath strobes
  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_accept     = 1'b0;
    w_overflow   = 1'b0;
    w_commit     = 1'b0;
    w_proto      = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_clear      = 1'b1;
          w_state_next = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        // A strobe in the same cycle download falls is still taken; the
        // write then drains before the block moves on to HOLD.
        if (ioctl_wr && w_in_range) begin
          w_accept     = 1'b1;
          w_state_next = S_WRITE;
        end else begin
          w_overflow = ioctl_wr;
          if (!ioctl_download) begin
            w_state_next = S_HOLD;
          end
        end
      end
      S_WRITE: begin
        w_proto = ioctl_wr;
        if (rom_ack) begin
          w_commit     = 1'b1;
          w_state_next = ioctl_download ? S_ACTIVE : S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_start) begin
          w_clear      = 1'b1;
          w_state_next = S_ACTIVE;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_finish     = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Counts cycles spent in HOLD; restarts whenever HOLD is re-entered
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_hold_cnt <= '0;
    end else if (r_state != S_HOLD) begin
      r_hold_cnt <= '0;
    end else begin
      r_hold_cnt <= r_hold_cnt + 8'd1;
    end
  end

  // CPU hold: raised at load start, released the cycle after DONE
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_cpu_hold <= 1'b0;
    end else if (w_clear) begin
      r_cpu_hold <= 1'b1;
    end else if (r_state == S_DONE) begin
      r_cpu_hold <= 1'b0;
    end
  end

  // ROM write port: latch address/data on accept, hold until acknowledged
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_rom_we     <= '0;
      r_ioctl_wait <= 1'b0;
      r_rom_addr   <= '0;
      r_rom_data   <= '0;
    end else if (w_accept) begin
      r_rom_we     <= w_sel;
      r_ioctl_wait <= 1'b1;
      r_rom_addr   <= ioctl_addr[REGION_AW-1:0];
      r_rom_data   <= ioctl_dout;
    end else if (w_commit) begin
      r_rom_we     <= '0;
      r_ioctl_wait <= 1'b0;
    end
  end

  // Load statistics and sticky error flags, cleared at each accepted load start
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_byte_count   <= '0;
      r_checksum     <= '0;
      r_err_overflow <= 1'b0;
      r_err_protocol <= 1'b0;
    end else if (w_clear) begin
      r_byte_count   <= '0;
      r_checksum     <= '0;
      r_err_overflow <= 1'b0;
      r_err_protocol <= 1'b0;
    end else begin
      if (w_commit) begin
        if (r_byte_count != '1) begin
          r_byte_count <= r_byte_count + ADDR_W'(1);
        end
        r_checksum <= r_checksum + {8'h00, r_rom_data};
      end
      if (w_overflow) begin
        r_err_overflow <= 1'b1;
      end
      if (w_proto) begin
        r_err_protocol <= 1'b1;
      end
    end
  end

  // Completion pulse and status, evaluated as HOLD expires so both are
  // visible during the single DONE cycle
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_load_done <= 1'b0;
      r_load_ok   <= 1'b0;
    end else begin
      r_load_done <= w_finish;
      if (w_clear) begin
        r_load_ok <= 1'b0;
      end else if (w_finish) begin
        r_load_ok <= (r_byte_count != '0) && !r_err_overflow && !r_err_protocol;
      end
    end
  end

  assign ioctl_wait   = r_ioctl_wait;
  assign rom_we       = r_rom_we;
  assign rom_addr     = r_rom_addr;
  assign rom_data     = r_rom_data;
  assign cpu_hold     = r_cpu_hold;
  assign load_done    = r_load_done;
  assign load_ok      = r_load_ok;
  assign byte_count   = r_byte_count;
  assign checksum     = r_checksum;
  assign err_overflow = r_err_overflow;
  assign err_protocol = r_err_protocol;

  a_we_onehot: assert property (@(posedge clk_sys) disable iff (reset)
    $onehot0(r_rom_we));

  a_write_pending: assert property (@(posedge clk_sys) disable iff (reset)
    (r_state == S_WRITE) |-> (r_ioctl_wait && (r_rom_we != '0)));

endmodule

// File: tb/tb_ioctl_rom_loader.sv
// Self-checking bench for ioctl_rom_loader: randomized loads compared
// against a queue-based model of which bytes land in which region.
module tb_ioctl_rom_loader;

  localparam int ADDR_W      = 25;
  localparam int NUM_REGIONS = 4;
  localparam int REGION_AW   = 15;
  localparam int HOLD_CYCLES = 16;
  localparam int REGION_SIZE = 2 ** REGION_AW;

  logic                   clk_sys = 1'b0;
  logic                   reset = 1'b0;
  logic                   ioctl_download = 1'b0;
  logic [7:0]             ioctl_index = 8'd0;
  logic                   ioctl_wr = 1'b0;
  logic [ADDR_W-1:0]      ioctl_addr = '0;
  logic [7:0]             ioctl_dout = 8'd0;
  logic                   ioctl_wait;
  logic [NUM_REGIONS-1:0] rom_we;
  logic [REGION_AW-1:0]   rom_addr;
  logic [7:0]             rom_data;
  logic                   rom_ack = 1'b1;
  logic                   cpu_hold;
  logic                   load_done;
  logic                   load_ok;
  logic [ADDR_W-1:0]      byte_count;
  logic [15:0]            checksum;
  logic                   err_overflow;
  logic                   err_protocol;

  ioctl_rom_loader #(
    .ADDR_W(ADDR_W),
    .NUM_REGIONS(NUM_REGIONS),
    .REGION_AW(REGION_AW),
    .LOAD_INDEX(8'd1),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .rom_we(rom_we),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .rom_ack(rom_ack),
    .cpu_hold(cpu_hold),
    .load_done(load_done),
    .load_ok(load_ok),
    .byte_count(byte_count),
    .checksum(checksum),
    .err_overflow(err_overflow),
    .err_protocol(err_protocol)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  // Observed accepted writes
  logic [NUM_REGIONS-1:0] mon_we[$];
  logic [REGION_AW-1:0]   mon_a[$];
  logic [7:0]             mon_d[$];

  // Stimulus bytes and model expectations
  logic [ADDR_W-1:0]      st_a[$];
  logic [7:0]             st_d[$];
  logic [NUM_REGIONS-1:0] exp_we[$];
  logic [REGION_AW-1:0]   exp_a[$];
  logic [7:0]             exp_d[$];
  int                     exp_count;
  int                     exp_sum;
  bit                     exp_ovf;
  bit                     exp_ok;

  // finish_load observations
  int obs_ticks;
  int obs_done_cnt;
  int obs_done_tick;
  logic obs_ok;

  // Write monitor, sampled mid-cycle
  always @(negedge clk_sys) begin
    if (!reset && rom_we !== '0) begin
      checks++;
      if ($countones(rom_we) != 1) begin
        errors++;
        $display("FAIL rom_we_onehot got=%b exp=one-hot", rom_we);
      end
      if (rom_ack === 1'b1) begin
        mon_we.push_back(rom_we);
        mon_a.push_back(rom_addr);
        mon_d.push_back(rom_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic clear_mon();
    mon_we.delete();
    mon_a.delete();
    mon_d.delete();
  endtask

  // Model: each byte lands in region addr/REGION_SIZE if that region exists
  task automatic model_compute();
    int unsigned region;
    exp_we.delete();
    exp_a.delete();
    exp_d.delete();
    exp_count = 0;
    exp_sum   = 0;
    exp_ovf   = 0;
    foreach (st_a[i]) begin
      region = int'(st_a[i]) / REGION_SIZE;
      if (region < NUM_REGIONS) begin
        exp_we.push_back(NUM_REGIONS'(1 << region));
        exp_a.push_back(REGION_AW'(int'(st_a[i]) % REGION_SIZE));
        exp_d.push_back(st_d[i]);
        exp_count++;
        exp_sum = (exp_sum + int'(st_d[i])) % 65536;
      end else begin
        exp_ovf = 1;
      end
    end
    exp_ok = (exp_count != 0) && !exp_ovf;
  endtask

  task automatic random_stim(input int n, input int unsigned max_addr);
    st_a.delete();
    st_d.delete();
    for (int i = 0; i < n; i++) begin
      st_a.push_back(ADDR_W'($urandom_range(0, max_addr)));
      st_d.push_back(8'($urandom));
    end
  endtask

  task automatic start_load(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    int n;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    n = 0;
    while (ioctl_wait && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL wait_timeout got=%0d exp=<50 cycles", n);
    end
  endtask

  task automatic send_all();
    foreach (st_a[i]) send_byte(st_a[i], st_d[i]);
  endtask

  task automatic finish_load();
    ioctl_download = 1'b0;
    tick();
    obs_ticks     = 0;
    obs_done_cnt  = 0;
    obs_done_tick = -1;
    obs_ok        = 1'bx;
    while (cpu_hold && obs_ticks < 200) begin
      tick();
      obs_ticks++;
      if (load_done) begin
        obs_done_cnt++;
        obs_done_tick = obs_ticks;
        obs_ok = load_ok;
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (load_done) obs_done_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    tick();
    tick();
    checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL rst_wait got=%b exp=0", ioctl_wait); end
    checks++; if (rom_we !== '0) begin errors++; $display("FAIL rst_we got=%b exp=0", rom_we); end
    checks++; if (rom_addr !== '0 || rom_data !== '0) begin errors++; $display("FAIL rst_addr_data got=%h/%h exp=0/0", rom_addr, rom_data); end
    checks++; if (cpu_hold !== 1'b0 || load_done !== 1'b0 || load_ok !== 1'b0) begin errors++; $display("FAIL rst_ctrl got=%b%b%b exp=000", cpu_hold, load_done, load_ok); end
    checks++; if (byte_count !== '0 || checksum !== '0) begin errors++; $display("FAIL rst_stats got=%h/%h exp=0/0", byte_count, checksum); end
    checks++; if (err_overflow !== 1'b0 || err_protocol !== 1'b0) begin errors++; $display("FAIL rst_err got=%b%b exp=00", err_overflow, err_protocol); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    st_a = '{25'd0, 25'd1, 25'd2, 25'd3};
    st_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    model_compute();
    clear_mon();
    start_load(8'd1);
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL basic_hold_start got=%b exp=1", cpu_hold); end
    send_all();
    finish_load();
    checks++; if (mon_we.size() != exp_we.size()) begin errors++; $display("FAIL basic_nwrites got=%0d exp=%0d", mon_we.size(), exp_we.size()); end
    else foreach (exp_we[i]) begin
      checks++;
      if (mon_we[i] !== exp_we[i] || mon_a[i] !== exp_a[i] || mon_d[i] !== exp_d[i]) begin
        errors++; $display("FAIL basic_write[%0d] got=%b/%h/%h exp=%b/%h/%h", i, mon_we[i], mon_a[i], mon_d[i], exp_we[i], exp_a[i], exp_d[i]);
      end
    end
    checks++; if (byte_count !== ADDR_W'(4)) begin errors++; $display("FAIL basic_count got=%0d exp=4", byte_count); end
    checks++; if (checksum !== 16'h00AA) begin errors++; $display("FAIL basic_checksum got=%h exp=00aa", checksum); end
    checks++; if (obs_done_cnt != 1 || obs_ok !== 1'b1) begin errors++; $display("FAIL basic_done got=%0d/%b exp=1/1", obs_done_cnt, obs_ok); end
    checks++; if (obs_ticks != HOLD_CYCLES + 1) begin errors++; $display("FAIL basic_hold_len got=%0d exp=%0d", obs_ticks, HOLD_CYCLES + 1); end
    checks++; if (obs_done_tick != HOLD_CYCLES) begin errors++; $display("FAIL basic_done_pos got=%0d exp=%0d", obs_done_tick, HOLD_CYCLES); end
  endtask

  task automatic test_regions();
    st_a = '{25'h08000, 25'h18005};
    st_d = '{8'h5A, 8'hC3};
    model_compute();
    clear_mon();
    start_load(8'd1);
    send_all();
    finish_load();
    checks++; if (mon_we.size() != 2) begin errors++; $display("FAIL regions_nwrites got=%0d exp=2", mon_we.size()); end
    else begin
      checks++; if (mon_we[0] !== 4'b0010 || mon_a[0] !== 15'h0000) begin errors++; $display("FAIL regions_w0 got=%b/%h exp=0010/0000", mon_we[0], mon_a[0]); end
      checks++; if (mon_we[1] !== 4'b1000 || mon_a[1] !== 15'h0005) begin errors++; $display("FAIL regions_w1 got=%b/%h exp=1000/0005", mon_we[1], mon_a[1]); end
    end
    checks++; if (checksum !== 16'(exp_sum) || load_ok !== 1'b1) begin errors++; $display("FAIL regions_stats got=%h/%b exp=%h/1", checksum, load_ok, 16'(exp_sum)); end
  endtask

  task automatic test_overflow();
    st_a = '{25'h00010, 25'h20000};
    st_d = '{8'h07, 8'hEE};
    model_compute();
    clear_mon();
    start_load(8'd1);
    send_all();
    finish_load();
    checks++; if (mon_we.size() != 1) begin errors++; $display("FAIL ovf_nwrites got=%0d exp=1", mon_we.size()); end
    checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", err_overflow); end
    checks++; if (byte_count !== ADDR_W'(1) || checksum !== 16'h0007) begin errors++; $display("FAIL ovf_stats got=%0d/%h exp=1/0007", byte_count, checksum); end
    checks++; if (obs_done_cnt != 1 || obs_ok !== 1'b0) begin errors++; $display("FAIL ovf_done got=%0d/%b exp=1/0", obs_done_cnt, obs_ok); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      random_stim($urandom_range(1, 12), 32'h27FFF);
      model_compute();
      clear_mon();
      start_load(8'd1);
      send_all();
      finish_load();
      checks++; if (mon_we.size() != exp_we.size()) begin errors++; $display("FAIL rand%0d_nwrites got=%0d exp=%0d", k, mon_we.size(), exp_we.size()); end
      else foreach (exp_we[i]) begin
        checks++;
        if (mon_we[i] !== exp_we[i] || mon_a[i] !== exp_a[i] || mon_d[i] !== exp_d[i]) begin
          errors++; $display("FAIL rand%0d_write[%0d] got=%b/%h/%h exp=%b/%h/%h", k, i, mon_we[i], mon_a[i], mon_d[i], exp_we[i], exp_a[i], exp_d[i]);
        end
      end
      checks++; if (byte_count !== ADDR_W'(exp_count) || checksum !== 16'(exp_sum)) begin errors++; $display("FAIL rand%0d_stats got=%0d/%h exp=%0d/%h", k, byte_count, checksum, exp_count, 16'(exp_sum)); end
      checks++; if (err_overflow !== exp_ovf || err_protocol !== 1'b0) begin errors++; $display("FAIL rand%0d_err got=%b%b exp=%b0", k, err_overflow, err_protocol, exp_ovf); end
      checks++; if (obs_done_cnt != 1 || obs_ok !== exp_ok) begin errors++; $display("FAIL rand%0d_done got=%0d/%b exp=1/%b", k, obs_done_cnt, obs_ok, exp_ok); end
    end
  endtask

  task automatic test_ack_delay();
    logic [ADDR_W-1:0] a;
    logic [7:0] d;
    logic [NUM_REGIONS-1:0] ewe;
    a = ADDR_W'($urandom_range(0, 32'h1FFFF));
    d = 8'($urandom);
    ewe = NUM_REGIONS'(1 << (int'(a) / REGION_SIZE));
    clear_mon();
    rom_ack = 1'b0;
    start_load(8'd1);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ioctl_wait !== 1'b1 || rom_we !== ewe || rom_addr !== REGION_AW'(int'(a) % REGION_SIZE) || rom_data !== d) begin
        errors++; $display("FAIL ackdly_hold[%0d] got=%b/%b/%h/%h exp=1/%b/%h/%h", i, ioctl_wait, rom_we, rom_addr, rom_data, ewe, REGION_AW'(int'(a) % REGION_SIZE), d);
      end
      if (i == 2) begin
        ioctl_addr = ADDR_W'(5);
        ioctl_dout = ~d;
        ioctl_wr   = 1'b1;
      end
      tick();
      ioctl_wr = 1'b0;
    end
    rom_ack = 1'b1;
    tick();
    checks++; if (ioctl_wait !== 1'b0 || rom_we !== '0) begin errors++; $display("FAIL ackdly_release got=%b/%b exp=0/0", ioctl_wait, rom_we); end
    finish_load();
    checks++; if (mon_we.size() != 1) begin errors++; $display("FAIL ackdly_nwrites got=%0d exp=1", mon_we.size()); end
    checks++; if (byte_count !== ADDR_W'(1) || checksum !== {8'h00, d}) begin errors++; $display("FAIL ackdly_stats got=%0d/%h exp=1/%h", byte_count, checksum, {8'h00, d}); end
    checks++; if (err_protocol !== 1'b1 || obs_ok !== 1'b0) begin errors++; $display("FAIL ackdly_proto got=%b/%b exp=1/0", err_protocol, obs_ok); end
  endtask

  task automatic test_other_index();
    logic [ADDR_W-1:0] bc;
    logic [15:0] cs;
    bc = byte_count;
    cs = checksum;
    clear_mon();
    ioctl_index    = 8'd2;
    ioctl_download = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ioctl_wr   = (i % 2 == 0);
      ioctl_addr = ADDR_W'(i);
      ioctl_dout = 8'($urandom);
      tick();
      checks++;
      if (cpu_hold !== 1'b0 || load_done !== 1'b0 || ioctl_wait !== 1'b0 || rom_we !== '0) begin
        errors++; $display("FAIL idx2_idle[%0d] got=%b%b%b/%b exp=000/0000", i, cpu_hold, load_done, ioctl_wait, rom_we);
      end
    end
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    tick();
    checks++; if (byte_count !== bc || checksum !== cs || mon_we.size() != 0) begin errors++; $display("FAIL idx2_stats got=%0d/%h/%0d exp=%0d/%h/0", byte_count, checksum, mon_we.size(), bc, cs); end
  endtask

  task automatic test_restart_in_hold();
    random_stim(2, 32'h1FFFF);
    start_load(8'd1);
    send_all();
    ioctl_download = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (cpu_hold !== 1'b1 || load_done !== 1'b0) begin errors++; $display("FAIL restart_inhold got=%b%b exp=10", cpu_hold, load_done); end
    ioctl_download = 1'b1;
    tick();
    checks++; if (cpu_hold !== 1'b1 || byte_count !== '0 || checksum !== '0) begin errors++; $display("FAIL restart_clear got=%b/%0d/%h exp=1/0/0", cpu_hold, byte_count, checksum); end
    random_stim(3, 32'h1FFFF);
    model_compute();
    clear_mon();
    send_all();
    finish_load();
    checks++; if (byte_count !== ADDR_W'(exp_count) || checksum !== 16'(exp_sum) || mon_we.size() != exp_we.size()) begin errors++; $display("FAIL restart_stats got=%0d/%h/%0d exp=%0d/%h/%0d", byte_count, checksum, mon_we.size(), exp_count, 16'(exp_sum), exp_we.size()); end
    checks++; if (obs_done_cnt != 1 || obs_ok !== 1'b1) begin errors++; $display("FAIL restart_done got=%0d/%b exp=1/1", obs_done_cnt, obs_ok); end
  endtask

  task automatic test_reset_mid_write();
    clear_mon();
    rom_ack = 1'b0;
    start_load(8'd1);
    ioctl_addr = ADDR_W'(32'h10004);
    ioctl_dout = 8'h9C;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    tick();
    checks++; if (rom_we !== 4'b0100 || ioctl_wait !== 1'b1) begin errors++; $display("FAIL rstmid_pending got=%b/%b exp=0100/1", rom_we, ioctl_wait); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (rom_we !== '0 || ioctl_wait !== 1'b0 || cpu_hold !== 1'b0) begin errors++; $display("FAIL rstmid_async got=%b/%b/%b exp=0000/0/0", rom_we, ioctl_wait, cpu_hold); end
    ioctl_download = 1'b0;
    rom_ack = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    checks++; if (cpu_hold !== 1'b0 || ioctl_wait !== 1'b0 || mon_we.size() != 0) begin errors++; $display("FAIL rstmid_idle got=%b/%b/%0d exp=0/0/0", cpu_hold, ioctl_wait, mon_we.size()); end
  endtask

  task automatic test_back_to_back();
    random_stim(8, 32'h1FFFF);
    model_compute();
    clear_mon();
    start_load(8'd1);
    send_all();
    finish_load();
    checks++; if (mon_we.size() != exp_we.size()) begin errors++; $display("FAIL b2b_nwrites got=%0d exp=%0d", mon_we.size(), exp_we.size()); end
    else foreach (exp_we[i]) begin
      checks++;
      if (mon_we[i] !== exp_we[i] || mon_a[i] !== exp_a[i] || mon_d[i] !== exp_d[i]) begin
        errors++; $display("FAIL b2b_write[%0d] got=%b/%h/%h exp=%b/%h/%h", i, mon_we[i], mon_a[i], mon_d[i], exp_we[i], exp_a[i], exp_d[i]);
      end
    end
    checks++; if (byte_count !== ADDR_W'(exp_count) || checksum !== 16'(exp_sum)) begin errors++; $display("FAIL b2b_stats got=%0d/%h exp=%0d/%h", byte_count, checksum, exp_count, 16'(exp_sum)); end
    checks++; if (obs_done_cnt != 1 || obs_ok !== 1'b1 || obs_ticks != HOLD_CYCLES + 1) begin errors++; $display("FAIL b2b_done got=%0d/%b/%0d exp=1/1/%0d", obs_done_cnt, obs_ok, obs_ticks, HOLD_CYCLES + 1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_regions();
    test_overflow();
    test_random();
    test_ack_delay();
    test_other_index();
    test_restart_in_hold();
    test_reset_mid_write();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/ioctl_rom_loader.md
Name: ioctl_rom_loader

Overview:
- Parametrised successor to the single-image ROM load path on the HPS ioctl bus.
- Routes download bytes for one menu index into NUM_REGIONS independent ROM write ports (BASIC, expansion ROM, font, PCG, ...).
- Applies back-pressure through ioctl_wait and holds the CPU in reset during the load.
- Reports byte count, checksum and error status when the load completes.

Parameters:
- ADDR_W, 25, ioctl_addr width.
- NUM_REGIONS, 4, number of ROM regions (1..8).
- REGION_AW, 15, address width of each region; region size = 2**REGION_AW bytes.
- LOAD_INDEX, 8'd1, ioctl_index value this loader accepts.
- HOLD_CYCLES, 16, extra cycles cpu_hold stays high after the last write (1..255).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ioctl_download  in  1  download in progress.
- ioctl_index  in  8  download index.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  ADDR_W  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  back-pressure to hps_io.
- rom_we  out  NUM_REGIONS  one-hot write request.
- rom_addr  out  REGION_AW  address within the region.
- rom_data  out  8  write data.
- rom_ack  in  1  write accepted by the selected region (may arrive in the same cycle rom_we rises).
- cpu_hold  out  1  hold the CPU in reset.
- load_done  out  1  one-cycle pulse at end of load.
- load_ok  out  1  status of the last load.
- byte_count  out  ADDR_W  accepted bytes, saturating.
- checksum  out  16  sum of accepted bytes, mod 2^16.
- err_overflow  out  1  sticky: a byte was addressed past the last region.
- err_protocol  out  1  sticky: ioctl_wr arrived while a write was pending.

Behaviour:
- Reset (async): state=IDLE. All outputs 0; rom_addr and rom_data 0.
- States: IDLE, ACTIVE, WRITE, HOLD, DONE.
- IDLE -> ACTIVE: on a cycle with ioctl_download=1 and ioctl_index==LOAD_INDEX.
  - Clears byte_count, checksum, err_overflow, err_protocol and load_ok.
  - Sets cpu_hold=1 (registered, high from the first ACTIVE cycle).
- Any other index is ignored entirely; the block stays in IDLE.
- ACTIVE, ioctl_wr=1:
  - Compute region = ioctl_addr >> REGION_AW.
  - If region < NUM_REGIONS: latch rom_addr = ioctl_addr[REGION_AW-1:0] and rom_data = ioctl_dout; set rom_we[region]=1 and ioctl_wait=1 on the next cycle; go to WRITE.
  - Otherwise: set err_overflow, drop the byte, stay in ACTIVE.
- WRITE: rom_we, rom_addr and rom_data stay stable until a cycle with rom_ack=1.
- On that ack cycle:
  - byte_count += 1, saturating at all-ones.
  - checksum += rom_data, 16-bit wrap.
  - rom_we and ioctl_wait drop on the next cycle.
  - Next state is ACTIVE if ioctl_download=1, otherwise HOLD.
- ioctl_wr during WRITE: set err_protocol and drop the byte; the pending write is unaffected.
- ioctl_download falls while ACTIVE: go to HOLD.
- ioctl_download falls while WRITE: the pending write completes first.
- HOLD: cpu_hold stays 1 for exactly HOLD_CYCLES cycles, then DONE.
- ioctl_download rising again during HOLD restarts the load: go to ACTIVE and clear the counters.
- DONE, one cycle:
  - load_done=1.
  - load_ok = (byte_count != 0) & !err_overflow & !err_protocol.
  - cpu_hold=0 from the next cycle; state returns to IDLE.
- byte_count, checksum, load_ok and the error flags hold their values until the next accepted load start.
- Throughput: at most one byte per 2 cycles with a same-cycle ack.
- rom_we is never multi-hot.
- Reset mid-write: rom_we drops asynchronously; no ack is required afterwards.

Test Plan:
- Load 4 bytes 0x11,0x22,0x33,0x44 at addr 0..3, index 1, rom_ack tied high.
  - rom_we=4'b0001 at rom_addr 0..3; byte_count=4; checksum=0x00AA.
  - load_done pulse; load_ok=1; cpu_hold falls HOLD_CYCLES+1 cycles after download falls.
- Write at addr 0x8000 and 0x18005 (REGION_AW=15).
  - rom_we=4'b0010 with rom_addr 0x0000, then 4'b1000 with rom_addr 0x0005.
- Write at addr 0x20000.
  - No rom_we; err_overflow=1; load_ok=0 at DONE; byte_count unchanged.
- rom_ack delayed 5 cycles; a second ioctl_wr arrives during the wait.
  - ioctl_wait high for the whole wait; rom_we, rom_addr and rom_data stable.
  - err_protocol=1; only the first byte is counted.
- Download with ioctl_index=2: no state change, cpu_hold stays 0, no load_done.
- reset asserted while in WRITE: rom_we, ioctl_wait and cpu_hold go to 0 immediately; state=IDLE.
- A new index-1 download then loads normally.
